// File: rtl/mips_muldiv_seq.sv
// Iterative signed MULT/DIV sequencer owning the HI/LO write path; one result bit per cycle.
// Optional MIPS_MULDIV_EARLY_TERM_EN: MUL exits once the remaining multiplier bits are zero.
module mips_muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_mult,
    input  logic                  start_div,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  hilo_access,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  hi_we,
    output logic                  lo_we,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic                  div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [2*W-1:0]  acc_q;
    logic [2*W-1:0]  mcand_q;
    logic [W-1:0]    mplier_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            is_div_q;
    logic            done_q;
    logic            dbz_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;

    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [2*W-1:0]  mul_acc_d;
    logic [W-1:0]    mplier_sh;
    logic [W:0]      rem_sh;
    logic            div_ge;
    logic [W:0]      rem_d;
    logic [W-1:0]    quo_d;
    logic            last_iter;
    logic            mul_exit;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    // During DIV, mplier_q holds dividend bits shifting out / quotient bits shifting in,
    // acc_q[W:0] holds the partial remainder and mcand_q[W-1:0] the divisor magnitude.
    always_comb begin
        mag_a     = operand_a[W-1] ? -operand_a : operand_a;
        mag_b     = operand_b[W-1] ? -operand_b : operand_b;
        mul_acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_sh = mplier_q >> 1;
        rem_sh    = {acc_q[W-1:0], mplier_q[W-1]};
        div_ge    = (rem_sh >= {1'b0, mcand_q[W-1:0]});
        rem_d     = div_ge ? (rem_sh - {1'b0, mcand_q[W-1:0]}) : rem_sh;
        quo_d     = {mplier_q[W-2:0], div_ge};
        last_iter = (cnt_q == CW'(W - 1));
`ifdef MIPS_MULDIV_EARLY_TERM_EN
        mul_exit  = last_iter || (mplier_sh == '0);
`else
        mul_exit  = last_iter;
`endif
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix   = (sign_a_q ^ sign_b_q) ? -mplier_q : mplier_q;
        rem_fix   = sign_a_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_mult || start_div) begin
                        sign_a_q <= operand_a[W-1];
                        sign_b_q <= operand_b[W-1];
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        is_div_q <= !start_mult;
                    end
                    // MULT takes priority when both starts arrive together.
                    if (start_mult) begin
                        mcand_q  <= {{W{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                        state_q  <= S_MUL;
                    end else if (start_div) begin
                        if (operand_b == '0) begin
                            hi_q    <= operand_a;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            mcand_q  <= {{W{1'b0}}, mag_b};
                            mplier_q <= mag_a;
                            state_q  <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= mul_acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_sh;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_exit) begin
                        state_q <= S_FIX;
                    end
                end
                S_DIV: begin
                    acc_q    <= {{(W-1){1'b0}}, rem_d};
                    mplier_q <= quo_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_iter) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign stall       = busy & (start_mult | start_div | hilo_access);
    assign done        = done_q;
    assign hi_we       = done_q;
    assign lo_we       = done_q;
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Bench for mips_muldiv_seq: directed and random MULT/DIV against a plain-arithmetic model.
module tb_mips_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mult;
    logic        start_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        hilo_access;
    logic        stall;
    logic        busy;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_by_zero;

    int vecs = 0;
    int errs = 0;

    mips_muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .start_div(start_div),
        .operand_a(operand_a), .operand_b(operand_b), .hilo_access(hilo_access),
        .stall(stall), .busy(busy), .done(done), .hi_we(hi_we), .lo_we(lo_we),
        .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: signed arithmetic on whole numbers, MIPS conventions for the corner cases.
    task automatic model(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat);
        longint p;
        int     q;
        int     r;
        logic [31:0] mb;
        int     it;
        dz = 1'b0;
        if (is_mul) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32];
            lo = p[31:0];
            lat = 34;
`ifdef MIPS_MULDIV_EARLY_TERM_EN
            mb = b[31] ? (32'd0 - b) : b;
            it = 1;
            for (int i = 0; i < 32; i++) if (mb[i]) it = i + 1;
            lat = it + 2;
`endif
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            hi = 32'd0; lo = 32'h8000_0000; lat = 34;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            hi = r; lo = q; lat = 34;
        end
    endtask

    // Issues one op at a negedge and follows it to done; lat=0 means the bound expired.
    task automatic run_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat, output logic side_ok);
        @(negedge clk);
        start_mult = is_mul; start_div = !is_mul; operand_a = a; operand_b = b;
        lat = 0; side_ok = 1'b1; hi = 'x; lo = 'x; dz = 1'bx;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start_mult = 1'b0; start_div = 1'b0;
                operand_a = $urandom; operand_b = $urandom;
            end
            if (busy !== 1'b1 || hi_we !== done || lo_we !== done) side_ok = 1'b0;
            if (done !== 1'b1 && div_by_zero !== 1'b0) side_ok = 1'b0;
            if (done === 1'b1) begin
                lat = i; hi = hi_out; lo = lo_out; dz = div_by_zero;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic is_mul,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ehi, elo, ahi, alo;
        logic edz, adz, side_ok;
        int elat, alat;
        model(is_mul, a, b, ehi, elo, edz, elat);
        run_op(is_mul, a, b, ahi, alo, adz, alat, side_ok);
        vecs += 5;
        if (alat !== elat) begin errs++; $display("FAIL %s latency got %0d want %0d (a=%h b=%h)", name, alat, elat, a, b); end
        if (ahi !== ehi) begin errs++; $display("FAIL %s hi got %h want %h (a=%h b=%h)", name, ahi, ehi, a, b); end
        if (alo !== elo) begin errs++; $display("FAIL %s lo got %h want %h (a=%h b=%h)", name, alo, elo, a, b); end
        if (adz !== edz) begin errs++; $display("FAIL %s div_by_zero got %b want %b", name, adz, edz); end
        if (side_ok !== 1'b1) begin errs++; $display("FAIL %s busy/we/dbz shape got %b want 1", name, side_ok); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_mult = 1'b0; start_div = 1'b0;
        operand_a = '0; operand_b = '0; hilo_access = 1'b0;
        repeat (2) @(negedge clk);
        start_mult = 1'b1; hilo_access = 1'b1;
        #1;
        vecs++;
        if ({busy, stall, done, hi_we, lo_we, div_by_zero} !== 6'b0) begin
            errs++; $display("FAIL reset_flags got %b want 000000", {busy, stall, done, hi_we, lo_we, div_by_zero});
        end
        vecs++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errs++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_out, lo_out);
        end
        @(negedge clk);
        start_mult = 1'b0; hilo_access = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle busy got %b want 0", busy); end
    endtask

    task automatic test_directed;
        logic [31:0] h0, l0;
        check_op("mult_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD);
        h0 = hi_out; l0 = lo_out;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || hi_out !== h0 || lo_out !== l0) begin
            errs++; $display("FAIL after_done got busy=%b done=%b hi=%h lo=%h want 0 0 %h %h", busy, done, hi_out, lo_out, h0, l0);
        end
        check_op("div_100_7", 1'b0, 32'd100, 32'd7);
        check_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        check_op("div_5_0", 1'b0, 32'd5, 32'd0);
        check_op("div_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op("mult_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
        check_op("mult_x_0", 1'b1, 32'h1234_5678, 32'd0);
        check_op("div_m9_m4", 1'b0, 32'hFFFF_FFF7, 32'hFFFF_FFFC);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: a = $urandom;
                1: a = $urandom_range(0, 20) - 10;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(0, 20) - 10;
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            check_op("random", $urandom_range(0, 1) == 1, a, b);
        end
    endtask

    task automatic test_hilo_stall;
        logic bad;
        int   lat;
        @(negedge clk);
        hilo_access = 1'b1;
        #1;
        vecs++;
        if (stall !== 1'b0) begin errs++; $display("FAIL idle_stall got %b want 0", stall); end
        hilo_access = 1'b0;
        @(negedge clk);
        start_mult = 1'b1; operand_a = 32'd11; operand_b = 32'h7000_0001;
        bad = 1'b0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start_mult = 1'b0; hilo_access = 1'b1;
            #1;
            if (stall !== 1'b1) bad = 1'b1;
            if (done === 1'b1) begin lat = i; break; end
        end
        vecs++;
        if (bad !== 1'b0 || lat == 0) begin errs++; $display("FAIL hilo_stall_busy got bad=%b lat=%0d want bad=0 lat>0", bad, lat); end
        @(negedge clk);
        #1;
        vecs++;
        if (stall !== 1'b0) begin errs++; $display("FAIL hilo_stall_release got %b want 0", stall); end
        hilo_access = 1'b0;
    endtask

    task automatic test_ignore_start;
        logic [31:0] ehi, elo;
        logic edz, st5, extra;
        int elat, lat;
        model(1'b1, 32'd12345, 32'h4000_0003, ehi, elo, edz, elat);
        @(negedge clk);
        start_mult = 1'b1; operand_a = 32'd12345; operand_b = 32'h4000_0003;
        lat = 0; st5 = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start_mult = 1'b0;
            start_div = (i == 5);
            if (i == 5) begin operand_a = 32'd99; operand_b = 32'd0; end
            #1;
            if (i == 5) st5 = stall;
            if (done === 1'b1) begin lat = i; break; end
        end
        start_div = 1'b0;
        vecs += 3;
        if (st5 !== 1'b1) begin errs++; $display("FAIL ignore_stall got %b want 1", st5); end
        if (lat !== elat) begin errs++; $display("FAIL ignore_latency got %0d want %0d", lat, elat); end
        if (hi_out !== ehi || lo_out !== elo) begin
            errs++; $display("FAIL ignore_result got %h/%h want %h/%h", hi_out, lo_out, ehi, elo);
        end
        extra = 1'b0;
        repeat (40) begin @(negedge clk); if (busy !== 1'b0 || done !== 1'b0) extra = 1'b1; end
        vecs++;
        if (extra !== 1'b0) begin errs++; $display("FAIL ignore_no_second_op got %b want 0", extra); end
        check_op("both_start_pre", 1'b1, 32'hFFFF_FF00, 32'd77);
        // Both starts together: must behave as MULT.
        begin
            logic [31:0] ahi, alo;
            logic adz, ok;
            int alat;
            model(1'b1, 32'hFFFF_FFF0, 32'd9, ehi, elo, edz, elat);
            @(negedge clk);
            start_mult = 1'b1; start_div = 1'b1; operand_a = 32'hFFFF_FFF0; operand_b = 32'd9;
            alat = 0; ahi = 'x; alo = 'x;
            for (int i = 1; i <= 200; i++) begin
                @(negedge clk);
                start_mult = 1'b0; start_div = 1'b0;
                if (done === 1'b1) begin alat = i; ahi = hi_out; alo = lo_out; break; end
            end
            ok = (alat == elat) && (ahi === ehi) && (alo === elo);
            vecs++;
            if (ok !== 1'b1) begin
                errs++; $display("FAIL both_start got lat=%0d %h/%h want lat=%0d %h/%h", alat, ahi, alo, elat, ehi, elo);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        @(negedge clk);
        start_div = 1'b1; operand_a = 32'd1000; operand_b = 32'd3;
        for (int i = 1; i <= 9; i++) begin @(negedge clk); start_div = 1'b0; end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if (busy !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errs++; $display("FAIL reset_mid got busy=%b we=%b%b hi=%h lo=%h want 0 00 0 0", busy, hi_we, lo_we, hi_out, lo_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin @(negedge clk); if (hi_we !== 1'b0 || lo_we !== 1'b0 || busy !== 1'b0) bad = 1'b1; end
        vecs++;
        if (bad !== 1'b0) begin errs++; $display("FAIL reset_mid_no_write got %b want 0", bad); end
        check_op("mult_2_3_after_rst", 1'b1, 32'd2, 32'd3);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_hilo_stall;
        test_ignore_start;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
